// File: rtl/wb_trace_serializer.sv
// rtl/wb_trace_serializer.sv - buffers register-file write-backs and emits them as 6-byte trace frames
module wb_trace_serializer #(
  parameter int         DEPTH   = 8,
  parameter bit         DROP_R0 = 1'b1,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic                       Clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_reg,
  input  logic [31:0]                wb_data,
  input  logic                       clr_stats,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_REG, S_D3, S_D2, S_D1, S_D0} state_t;

  state_t          state, next_state;
  logic [36:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [36:0]     frame_q;
  logic            push_req, push_ok, drop, pop, full, hs;

  // Fullness is judged before the edge, so a same-edge pop never rescues a push.
  assign full     = (count == CW'(DEPTH));
  assign push_req = wb_valid && !(DROP_R0 && (wb_reg == 5'd0));
  assign push_ok  = push_req && !full;
  assign drop     = push_req && full;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign hs       = tx_valid && tx_ready;

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= {wb_reg, wb_data};
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop on the same edge as clr_stats leaves exactly that one drop recorded.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clr_stats ? 8'd1 : ((drop_count == 8'hFF) ? 8'hFF : drop_count + 8'd1);
    end else if (clr_stats) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      frame_q <= '0;
    end else begin
      state <= next_state;
      if (pop) frame_q <= mem[rd_ptr];
    end
  end

  // Outputs decode only registered state, so tx_ready never reaches tx_valid/tx_data.
  always_comb begin
    next_state = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      S_IDLE: if (pop) next_state = S_SYNC;
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC;
        if (hs) next_state = S_REG;
      end
      S_REG: begin
        tx_valid = 1'b1;
        tx_data  = {3'b000, frame_q[36:32]};
        if (hs) next_state = S_D3;
      end
      S_D3: begin
        tx_valid = 1'b1;
        tx_data  = frame_q[31:24];
        if (hs) next_state = S_D2;
      end
      S_D2: begin
        tx_valid = 1'b1;
        tx_data  = frame_q[23:16];
        if (hs) next_state = S_D1;
      end
      S_D1: begin
        tx_valid = 1'b1;
        tx_data  = frame_q[15:8];
        if (hs) next_state = S_D0;
      end
      S_D0: begin
        tx_valid = 1'b1;
        tx_data  = frame_q[7:0];
        if (hs) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE) || (count != '0);
  assign fifo_count = count;

endmodule

// File: tb/tb_wb_trace_serializer.sv
// tb/tb_wb_trace_serializer.sv - scoreboard bench for wb_trace_serializer
module tb_wb_trace_serializer;

  logic        Clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        clr_stats;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          acc;
  } vec_t;

  wb_trace_serializer #(.DEPTH(8), .DROP_R0(1'b1), .SYNC(8'hA5)) dut (
    .Clk(Clk), .rst(rst), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .clr_stats(clr_stats), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame(input logic [4:0] r, input logic [31:0] d);
    sb.push_back(8'hA5);
    sb.push_back({3'b000, r});
    sb.push_back(d[31:24]);
    sb.push_back(d[23:16]);
    sb.push_back(d[15:8]);
    sb.push_back(d[7:0]);
  endtask

  task automatic do_write(input logic [4:0] r, input logic [31:0] d, input bit acc);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
    if (acc) push_frame(r, d);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy && sb.size() == 0) break;
      tick();
    end
    check("drain_done", {31'd0, (busy || sb.size() != 0)}, 32'd0);
  endtask

  always @(negedge Clk) begin
    if (rst === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  vec_t tbl [6];

  initial begin
    tbl[0] = '{5'd3,  32'hDEADBEEF, 1'b1};
    tbl[1] = '{5'd0,  32'h11111111, 1'b0};
    tbl[2] = '{5'd31, 32'hFFFFFFFF, 1'b1};
    tbl[3] = '{5'd17, 32'h00000000, 1'b1};
    tbl[4] = '{5'd0,  32'h00000000, 1'b0};
    tbl[5] = '{5'd1,  32'h80000001, 1'b1};

    rst = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0; clr_stats = 1'b0; tx_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // basic frame latency and byte order
    do_write(5'd8, 32'h1234ABCD, 1'b1);
    check("t1_valid_n", {31'd0, tx_valid}, 32'd0);
    check("t1_count_n", {28'd0, fifo_count}, 32'd1);
    check("t1_busy_n", {31'd0, busy}, 32'd1);
    tick();
    check("t1_valid_n1", {31'd0, tx_valid}, 32'd1);
    check("t1_sync_n1", {24'd0, tx_data}, 32'hA5);
    check("t1_count_n1", {28'd0, fifo_count}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t1_d0", {24'd0, tx_data}, 32'hCD);
    tick();
    check("t1_idle_valid", {31'd0, tx_valid}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_sb_empty", sb.size(), 32'd0);

    // table of single writes, including dropped r0 writes
    foreach (tbl[k]) begin
      do_write(tbl[k].r, tbl[k].d, tbl[k].acc);
      check("tbl_count", {28'd0, fifo_count}, {31'd0, tbl[k].acc});
      check("tbl_drop", {24'd0, drop_count}, 32'd0);
      check("tbl_ovf", {31'd0, overflow}, 32'd0);
      drain(20);
    end

    // stall in D2
    do_write(5'd8, 32'h1234ABCD, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_data", {24'd0, tx_data}, 32'h34);
      check("t2_hold_valid", {31'd0, tx_valid}, 32'd1);
      tick();
    end
    tx_ready = 1'b1;
    drain(20);

    // back-to-back writes into a stalled consumer: one in frame reg, eight queued, one dropped
    tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) do_write(5'(i), 32'hA0000000 + 32'(i), i <= 9);
    check("t4_count", {28'd0, fifo_count}, 32'd8);
    check("t4_drop", {24'd0, drop_count}, 32'd1);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_stall_sync", {24'd0, tx_data}, 32'hA5);
    tx_ready = 1'b1;
    drain(120);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    check("t4_clr_ovf", {31'd0, overflow}, 32'd0);
    check("t4_clr_drop", {24'd0, drop_count}, 32'd0);

    // drop counter saturation and clear-vs-drop priority
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) do_write(5'((i % 31) + 1), 32'(i), i < 9);
    check("t5_drop_sat", {24'd0, drop_count}, 32'd255);
    check("t5_ovf", {31'd0, overflow}, 32'd1);
    check("t5_count", {28'd0, fifo_count}, 32'd8);
    clr_stats = 1'b1;
    do_write(5'd5, 32'h55555555, 1'b0);
    clr_stats = 1'b0;
    check("t5_clrdrop_ovf", {31'd0, overflow}, 32'd1);
    check("t5_clrdrop_cnt", {24'd0, drop_count}, 32'd1);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    check("t5_clr_ovf", {31'd0, overflow}, 32'd0);
    check("t5_clr_drop", {24'd0, drop_count}, 32'd0);
    tx_ready = 1'b1;
    drain(120);

    // asynchronous reset in D1 with three entries queued
    do_write(5'd1, 32'hCAFEF00D, 1'b1);
    do_write(5'd2, 32'h22222222, 1'b0);
    do_write(5'd3, 32'h33333333, 1'b0);
    do_write(5'd4, 32'h44444444, 1'b0);
    tick(); tick();
    check("t6_in_d1", {24'd0, tx_data}, 32'hF0);
    check("t6_count3", {28'd0, fifo_count}, 32'd3);
    #1 rst = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, tx_valid}, 32'd0);
    check("t6_async_count", {28'd0, fifo_count}, 32'd0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    tick(); tick();
    rst = 1'b1;
    tick();
    do_write(5'd7, 32'h0BADC0DE, 1'b1);
    tick();
    check("t6_new_valid", {31'd0, tx_valid}, 32'd1);
    check("t6_new_sync", {24'd0, tx_data}, 32'hA5);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
